fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Upstream fetch/PC stage of the single-issue femtoRV32 core.
- Owns the program counter and fetches each instruction over a req/ready handshake to instruction memory.
- Presents the instruction for one execute cycle to decode/control (opcode bits [6:2] drive the control unit).
- Consumes the control unit's PC_Sel, Jump and endProgram, plus the branch decision, to compute the next PC. Halts on endProgram or a misaligned target, and counts retired instructions.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until imem_ready.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory accepts request and returns data in the same cycle.
- instr  out  32  latched instruction, stable from EXEC until the next fetch completes.
- instr_valid  out  1  high for exactly the EXEC cycle.
- pc  out  XLEN  address of the current instruction.
- pc_plus4  out  XLEN  pc+4, used for JAL/JALR write-back.
- pc_sel  in  2  from control: 00 PC+4, 01 PC+imm, 10 rs1+imm, 11 halt.
- jump  in  1  from control; qualifies pc_sel=01 unconditionally.
- branch_taken  in  1  branch comparator result; qualifies pc_sel=01.
- end_program  in  1  from control; halt request.
- imm  in  XLEN  sign-extended immediate from the immediate generator.
- rs1_val  in  XLEN  register-file rs1 read data.
- halted  out  1  core stopped.
- fault  out  1  halted because of a misaligned target.
- instret  out  32  retired-instruction counter.

Behaviour:
- Reset (async, rst_n=0) forces all outputs and state immediately:
  - state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - instr_valid=0, halted=0, fault=0, instret=0.
  - imem_req=0 while rst_n=0; imem_req goes to 1 in the first cycle after deassertion.
- FSM has three states: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a rising edge with imem_ready=1: instr<=imem_rdata, state->EXEC.
  - Otherwise stay in FETCH with no timeout.
  - Minimum fetch latency is 1 cycle.
- EXEC (one cycle):
  - instr_valid=1, imem_req=0; imem_ready is ignored.
  - If end_program=1 or pc_sel=11: state->HALT, pc unchanged, instret unchanged.
  - Otherwise compute the target:
    - pc_sel=00: pc+4.
    - pc_sel=01: pc+imm if (jump|branch_taken), else pc+4.
    - pc_sel=10: (rs1_val+imm) & ~1.
  - If target[1:0]!=00: state->HALT, fault<=1, pc unchanged, instret unchanged.
  - Else: pc<=target, instret<=instret+1, state->FETCH.
- HALT:
  - Terminal: halted=1, imem_req=0, instr_valid=0.
  - All inputs ignored; exit only by reset.
- Arithmetic: all adds are modulo 2^XLEN; pc wraps silently, e.g. 32'hFFFF_FFFC+4 = 0. instret wraps from 32'hFFFF_FFFF to 0.
- end_program takes priority over the misaligned check. Simultaneous end_program=1 with pc_sel=10 gives halt, fault=0.
- pc_plus4 is combinational pc+4 and valid in all states.
- Reset asserted mid-fetch or mid-EXEC aborts immediately. No instret update and no pc update from the aborted instruction.
- Throughput: 1 instruction per (fetch latency + 1) cycles. With a zero-wait memory that is 2 cycles per instruction.

Test Plan:
- Reset and sequential run: release rst_n, imem_ready=1 constantly, all instructions ADDI (pc_sel=00). Required: pc 0,4,8,12; instr_valid toggles every other cycle; instret=3 after the third EXEC.
- Wait states: hold imem_ready=0 for 3 cycles at pc=8. Required: imem_req and imem_addr=8 stable for 4 cycles; instr_valid only after ready; instret not incremented while waiting.
- Branch and JAL: pc=0x10, pc_sel=01, imm=-8:
  - branch_taken=0 -> next pc 0x14.
  - branch_taken=1 -> next pc 0x08.
  - jump=1 with imm=0x100 -> next pc 0x110; pc_plus4=0x14 during EXEC.
- JALR: pc_sel=10, rs1_val=0x203, imm=0 -> target 0x202, halt with fault=1, pc stays.
- JALR aligned: rs1_val=0x201, imm=3 -> pc 0x204.
- Halt: end_program=1 at pc=0x40 -> halted=1 next cycle, pc=0x40, imem_req=0 forever. Then pulse rst_n low mid-cycle -> pc=RESET_PC and halted=0 immediately (asynchronous).

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch / PC stage of the femtoRV32 core: fetches over a req/ready handshake,
// presents each instruction for one EXEC cycle, then resolves the next PC.
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      pc_sel,
    input  logic            jump,
    input  logic            branch_taken,
    input  logic            end_program,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);
    localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    state_t          state_r, state_n;
    logic [XLEN-1:0] pc_r, pc_n;
    logic [31:0]     instr_r, instr_n;
    logic [31:0]     instret_r, instret_n;
    logic            fault_r, fault_n;
    logic            req_r, valid_r, halted_r;
    logic [XLEN-1:0] pc_plus4_s, target_s;
    logic            halt_req_s, misaligned_s;

    // Branch/jump target selection and halt qualification for the EXEC cycle
    always_comb begin
        pc_plus4_s = pc_r + PC_STEP;
        target_s   = pc_plus4_s;
        case (pc_sel)
            2'b00:   target_s = pc_plus4_s;
            2'b01:   target_s = (jump || branch_taken) ? (pc_r + imm) : pc_plus4_s;
            2'b10:   target_s = (rs1_val + imm) & LSB_CLEAR;
            default: target_s = pc_plus4_s;
        endcase
        halt_req_s   = end_program || (pc_sel == 2'b11);
        misaligned_s = (target_s[1:0] != 2'b00);
    end

    // Next-state and datapath update logic
    always_comb begin
        state_n   = state_r;
        pc_n      = pc_r;
        instr_n   = instr_r;
        instret_n = instret_r;
        fault_n   = fault_r;
        case (state_r)
            S_FETCH: begin
                // req_r gates acceptance so the idle cycle right after reset cannot fetch
                if (req_r && imem_ready) begin
                    instr_n = imem_rdata;
                    state_n = S_EXEC;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_EXEC: begin
                if (halt_req_s) begin
                    state_n = S_HALT;
                end else if (misaligned_s) begin
                    state_n = S_HALT;
                    fault_n = 1'b1;
                end else begin
                    pc_n      = target_s;
                    instret_n = instret_r + 32'd1;
                    state_n   = S_FETCH;
                end
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_HALT;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            pc_r      <= RESET_PC;
            instr_r   <= NOP_INSTR;
            instret_r <= 32'd0;
            fault_r   <= 1'b0;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_n;
            pc_r      <= pc_n;
            instr_r   <= instr_n;
            instret_r <= instret_n;
            fault_r   <= fault_n;
            req_r     <= (state_n == S_FETCH);
            valid_r   <= (state_n == S_EXEC);
            halted_r  <= (state_n == S_HALT);
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign instret     = instret_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed instruction stream with
// hand-computed PCs; a monitor checks every EXEC cycle against the queue.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_sel;
    logic        jump;
    logic        branch_taken;
    logic        end_program;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        halted;
    logic        fault;
    logic [31:0] instret;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic [31:0] instret;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   instr_k  = 0;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .pc_sel(pc_sel), .jump(jump), .branch_taken(branch_taken),
        .end_program(end_program), .imm(imm), .rs1_val(rs1_val),
        .halted(halted), .fault(fault), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every EXEC cycle must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_exec: pc %h with empty scoreboard", pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("exec_pc", pc, e.pc);
                chk("exec_instr", instr, e.instr);
                chk("exec_pc_plus4", pc_plus4, e.pc_plus4);
                chk("exec_instret", instret, e.instret);
                chk("exec_req_low", {31'd0, imem_req}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] addi_word(input int k);
        logic [11:0] k12;
        k12 = 12'(k);
        return {k12, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    // One instruction: wait for the request, insert wait states, deliver, run EXEC.
    task automatic step(input logic [31:0] exp_pc, input int waits,
                        input logic [1:0] sel, input logic j, input logic bt,
                        input logic ep, input logic [31:0] im, input logic [31:0] rs1,
                        input logic [31:0] exp_instret);
        exp_t e;
        int   n;
        logic [31:0] word;
        word = addi_word(instr_k);
        instr_k++;
        e.pc = exp_pc; e.instr = word; e.pc_plus4 = exp_pc + 32'd4; e.instret = exp_instret;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            chk("req_timeout", {31'd0, imem_req}, 32'd1);
        end
        sb.push_back(e);
        imem_ready = 1'b0;
        for (int w = 0; w < waits; w++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_instret", instret, exp_instret);
            chk("wait_no_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        chk("fetch_addr", imem_addr, exp_pc);
        imem_rdata = word; imem_ready = 1'b1;
        pc_sel = sel; jump = j; branch_taken = bt; end_program = ep; imm = im; rs1_val = rs1;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
    endtask

    task automatic check_halted(input logic [31:0] exp_pc, input logic exp_fault,
                                input logic [31:0] exp_instret);
        imem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_fault", {31'd0, fault}, {31'd0, exp_fault});
            chk("halt_pc", pc, exp_pc);
            chk("halt_instret", instret, exp_instret);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        imem_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, pc, 32'h0000_0000);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_instret"}, instret, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; imem_rdata = 32'd0; imem_ready = 1'b0;
        pc_sel = 2'b00; jump = 1'b0; branch_taken = 1'b0; end_program = 1'b0;
        imm = 32'd0; rs1_val = 32'd0;
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential run, wait states at pc 8, then branches and jumps
        step(32'h0000_0000, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        step(32'h0000_0004, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1);
        step(32'h0000_0008, 3, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd2);
        chk("instret_after_3", instret, 32'd3);
        step(32'h0000_000C, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd3);
        step(32'h0000_0010, 0, 2'b01, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0, 32'd4);
        chk("branch_not_taken_pc", pc, 32'h0000_0014);
        step(32'h0000_0014, 1, 2'b01, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd5);
        step(32'h0000_0010, 0, 2'b01, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, 32'd6);
        chk("branch_taken_pc", pc, 32'h0000_0008);
        step(32'h0000_0008, 0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd8, 32'h0000_0008, 32'd7);
        step(32'h0000_0010, 0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'd8);
        chk("jal_pc", pc, 32'h0000_0110);
        step(32'h0000_0110, 0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd3, 32'h0000_0201, 32'd9);
        chk("jalr_aligned_pc", pc, 32'h0000_0204);
        step(32'h0000_0204, 0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0203, 32'd10);
        check_halted(32'h0000_0204, 1'b1, 32'd10);

        // Asynchronous reset out of the faulted halt
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_fault");
        @(negedge clk);
        rst_n = 1'b1;
        instr_k = 0;

        // PC wrap, then end_program beating a misaligned JALR target
        step(32'h0000_0000, 0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC, 32'd0);
        chk("wrap_target_pc", pc, 32'hFFFF_FFFC);
        step(32'hFFFF_FFFC, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1);
        chk("wrap_pc", pc, 32'h0000_0000);
        step(32'h0000_0000, 0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'd0, 32'd2);
        step(32'h0000_0040, 0, 2'b10, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0000_0003, 32'd3);
        check_halted(32'h0000_0040, 1'b0, 32'd3);

        // Mid-cycle reset pulse while halted
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_halt");
        @(negedge clk);
        rst_n = 1'b1;
        instr_k = 0;
        step(32'h0000_0000, 0, 2'b11, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        check_halted(32'h0000_0000, 1'b0, 32'd0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
